ufp_write_buffer: RTL and testbench
===================================

Name: ufp_write_buffer

Overview:
- Small in-order store buffer sitting directly upstream of the write-data demux in the cache datapath.
- Accepts CPU-side word writes (address, data, byte mask) and queues them.
- Presents the oldest pending write to the cache controller, which derives line_select and offset and feeds the demux.
- Merges back-to-back writes to the same word and exposes a probe so reads can stall on read-after-write hazards.

Parameters:
DEPTH, 4, number of buffered word entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream write request valid
in_ready  out  1  buffer can accept (push or merge) this cycle
in_addr  in  32  byte address of write; [1:0] ignored
in_wdata  in  32  write data, byte lanes aligned to word
in_wmask  in  4  byte enables
out_valid  out  1  head entry valid
out_ready  in  1  cache controller consumes head this cycle
out_addr  out  32  head word address, [1:0] = 2'b00
out_wdata  out  32  head data; disabled bytes are 0
out_wmask  out  4  head byte enables
probe_addr  in  32  read address to check for hazard
probe_hit  out  1  some buffered or accepted-this-cycle write targets probe word
empty  out  1  count == 0

Behaviour:
- Reset (async, rst_n low): count=0, head=tail=0, all entry storage cleared. Outputs: out_valid=0, out_addr/out_wdata/out_wmask=0, empty=1, in_ready=1, probe_hit=0. Reset mid-operation discards all pending entries immediately.
- Storage: circular FIFO of DEPTH entries {word_addr[29:0], data[31:0], mask[3:0]}, head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, count 0..DEPTH.
- out_* are driven combinationally from the head entry. out_valid = (count != 0).
- Pop: out_valid && out_ready at the clock edge advances head and decrements count.
- Out-stability rule: while out_valid=1 and out_ready=0, out_addr/wdata/wmask must not change.
- Accept: in_valid && in_ready at the clock edge. The write is visible on out_* no earlier than the next cycle (latency 1, no bypass).
- Merge condition: count >= 2 AND in_addr[31:2] == youngest entry word_addr.
  - Per byte with in_wmask[i]=1, overwrite data byte i; mask |= in_wmask.
  - count and tail are unchanged.
  - The head is never a merge target.
- New-entry condition: otherwise. Write {in_addr[31:2], in_wdata masked by in_wmask, in_wmask} at tail; tail++, count++. Same-word writes with count==1 become a separate entry.
- in_ready = (count < DEPTH) || merge condition. It does not depend on out_ready, so a push is not accepted in the cycle a full buffer pops; in_ready rises the cycle after the pop.
- in_wmask == 4'b0000 with in_valid: handshake completes normally (in_ready as above), nothing stored, count unchanged.
- Simultaneous push and pop with count < DEPTH: both occur and count is unchanged. Simultaneous merge and pop with count==2: a merge into the youngest entry is legal because it is not the head.
- probe_hit: OR over valid entries of (word_addr == probe_addr[31:2]), OR'd with (in_valid && in_ready && in_wmask != 0 && in_addr[31:2] == probe_addr[31:2]). The entry being popped this cycle still counts.
- empty = (count == 0).
- All arithmetic is unsigned. Pointer wrap uses natural log2(DEPTH)-bit overflow.

Decomposition:
- Shared package (cache_pkg): wb_entry_t struct {word_addr[29:0], data[31:0], mask[3:0]}; WB_DEPTH default constant.
- One combinational sub-module: wb_byte_merge. Inputs: old data/mask and new data/mask. Outputs: merged data/mask. Used for both new-entry masking and merge.

Test Plan:
- Reset: rst_n=0 asynchronously mid-clock with 3 entries queued -> immediately out_valid=0, empty=1, in_ready=1. After release, first push appears on out_* one cycle later.
- Ordering and full: out_ready=0, push 0x1000/0x11111111/F, 0x1004/0x22222222/F, 0x1008/.../F, 0x100C/.../F -> in_ready=0 after 4th. Then out_ready=1 pops in order 0x1000, 0x1004, 0x1008, 0x100C. in_ready=1 the cycle after the first pop.
- Merge: out_ready=0. Push 0x1000/0xAA/0001, then 0x2000/0x00001122/0011, then 0x2002/0x33440000/1100 -> count=2, second entry data=0x33441122, mask=1111. Head stays 0x1000 unchanged.
- No merge into head: push 0x3000/0x000000AA/0001, then 0x3001/0x0000BB00/0010 with count==1 -> count=2, head data still 0x000000AA/0001.
- Full, same-cycle pop: count=4, in_valid=1 to a new word, out_ready=1 -> that cycle pops only, count=3. The write is accepted the next cycle, count=4.
- Probe and zero mask: entries at 0x4000 and 0x4008, probe_addr=0x4003 -> probe_hit=1. probe_addr=0x4004 -> 0. Push with in_wmask=0 -> handshake completes, count unchanged, probe_hit=0 for that address.

Source files
------------

// File: rtl/ufp_write_buffer_pkg.sv
// Shared types for the UFP store buffer: the buffered entry layout and default depth.
package ufp_write_buffer_pkg;

  localparam int WB_DEPTH = 4;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wb_entry_t;

endpackage

// File: rtl/ufp_write_buffer_byte_merge.sv
// Byte-lane merge: enabled new bytes replace old ones, masks accumulate.
module wb_byte_merge (
  input  logic [31:0] old_data,
  input  logic [3:0]  old_mask,
  input  logic [31:0] new_data,
  input  logic [3:0]  new_mask,
  output logic [31:0] merged_data,
  output logic [3:0]  merged_mask
);

  always_comb begin
    merged_data = old_data;
    for (int i = 0; i < 4; i++) begin
      if (new_mask[i]) merged_data[8*i +: 8] = new_data[8*i +: 8];
    end
    merged_mask = old_mask | new_mask;
  end

endmodule

// File: rtl/ufp_write_buffer.sv
// In-order word store buffer with youngest-entry write merging and a RAW hazard probe.
module ufp_write_buffer
  import ufp_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wmask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_wmask,
  input  logic [31:0] probe_addr,
  output logic        probe_hit,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] TWO_CNT  = (PW+1)'(2);

  wb_entry_t      entries_q [DEPTH];
  wb_entry_t      entries_d [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d, young_ptr;
  logic [PW:0]    count_q, count_d;

  logic           merge_hit, accept, do_merge, do_push, pop;
  logic [31:0]    old_data, merged_data;
  logic [3:0]     old_mask, merged_mask;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^{in_addr[1:0], probe_addr[1:0]};

  assign young_ptr = tail_q - 1'b1;
  // The head can never be the youngest entry once two or more are queued.
  assign merge_hit = (count_q >= TWO_CNT) && (in_addr[31:2] == entries_q[young_ptr].word_addr);
  assign in_ready  = (count_q < FULL_CNT) || merge_hit;
  assign accept    = in_valid && in_ready;
  assign do_merge  = accept && (in_wmask != 4'b0000) && merge_hit;
  assign do_push   = accept && (in_wmask != 4'b0000) && !merge_hit;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_addr  = {entries_q[head_q].word_addr, 2'b00};
  assign out_wdata = entries_q[head_q].data;
  assign out_wmask = entries_q[head_q].mask;
  assign empty     = (count_q == '0);

  // A fresh entry merges against an all-zero word so disabled lanes read back as 0.
  assign old_data = merge_hit ? entries_q[young_ptr].data : 32'h0;
  assign old_mask = merge_hit ? entries_q[young_ptr].mask : 4'h0;

  wb_byte_merge u_merge (
    .old_data    (old_data),
    .old_mask    (old_mask),
    .new_data    (in_wdata),
    .new_mask    (in_wmask),
    .merged_data (merged_data),
    .merged_mask (merged_mask)
  );

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (do_merge) begin
      entries_d[young_ptr].data = merged_data;
      entries_d[young_ptr].mask = merged_mask;
    end
    if (do_push) begin
      entries_d[tail_q] = '{word_addr: in_addr[31:2], data: merged_data, mask: merged_mask};
      tail_d = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, pop};
  end

  always_comb begin : probe_blk
    logic [PW-1:0] off;
    off       = '0;
    probe_hit = accept && (in_wmask != 4'b0000) && (in_addr[31:2] == probe_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) && (entries_q[i].word_addr == probe_addr[31:2]))
        probe_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_ufp_write_buffer.sv
// Directed table-driven bench for ufp_write_buffer plus async-reset corner sequence.
module tb_ufp_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata;
  logic [3:0]  in_wmask;
  logic        out_valid, out_ready;
  logic [31:0] out_addr, out_wdata;
  logic [3:0]  out_wmask;
  logic [31:0] probe_addr;
  logic        probe_hit, empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ufp_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_wmask(in_wmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_wdata(out_wdata), .out_wmask(out_wmask),
    .probe_addr(probe_addr), .probe_hit(probe_hit), .empty(empty)
  );

  typedef struct {
    logic        iv;
    logic [31:0] a, d;
    logic [3:0]  m;
    logic        ordy;
    logic [31:0] pa;
    logic        e_ov;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_mask;
    logic        e_ir, e_ph, e_emp;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic iv, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input logic ordy, input logic [31:0] pa,
                      input logic e_ov, input logic [31:0] e_addr, input logic [31:0] e_data,
                      input logic [3:0] e_mask, input logic e_ir, input logic e_ph,
                      input logic e_emp);
    vec_t v;
    v.iv = iv; v.a = a; v.d = d; v.m = m; v.ordy = ordy; v.pa = pa;
    v.e_ov = e_ov; v.e_addr = e_addr; v.e_data = e_data; v.e_mask = e_mask;
    v.e_ir = e_ir; v.e_ph = e_ph; v.e_emp = e_emp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic ordy, input logic [31:0] pa);
    in_valid = iv; in_addr = a; in_wdata = d; in_wmask = m;
    out_ready = ordy; probe_addr = pa;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);

    // iv  addr        data          mask ordy probe        ov addr        data          mask ir ph emp
    // ordering and full
    addv(1, 32'h1000, 32'h11111111, 4'hF, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    addv(1, 32'h1004, 32'h22222222, 4'hF, 0, 32'h0,      1, 32'h1000, 32'h11111111, 4'hF, 1, 0, 0);
    addv(1, 32'h1008, 32'h33333333, 4'hF, 0, 32'h0,      1, 32'h1000, 32'h11111111, 4'hF, 1, 0, 0);
    addv(1, 32'h100C, 32'h44444444, 4'hF, 0, 32'h0,      1, 32'h1000, 32'h11111111, 4'hF, 1, 0, 0);
    addv(1, 32'h1010, 32'h55555555, 4'hF, 0, 32'h0,      1, 32'h1000, 32'h11111111, 4'hF, 0, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h1000, 32'h11111111, 4'hF, 0, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h1004, 32'h22222222, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h1008, 32'h33333333, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h100C, 32'h44444444, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    // merge into youngest, head untouched
    addv(1, 32'h1000, 32'h000000AA, 4'h1, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    addv(1, 32'h2000, 32'h00001122, 4'h3, 0, 32'h0,      1, 32'h1000, 32'h000000AA, 4'h1, 1, 0, 0);
    addv(1, 32'h2002, 32'h33440000, 4'hC, 0, 32'h2001,   1, 32'h1000, 32'h000000AA, 4'h1, 1, 1, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h2000,   1, 32'h1000, 32'h000000AA, 4'h1, 1, 1, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h1000, 32'h000000AA, 4'h1, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h2000, 32'h33441122, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    // same word with count==1 is a separate entry
    addv(1, 32'h3000, 32'h000000AA, 4'h1, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    addv(1, 32'h3001, 32'h0000BB00, 4'h2, 0, 32'h0,      1, 32'h3000, 32'h000000AA, 4'h1, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,      1, 32'h3000, 32'h000000AA, 4'h1, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h3000, 32'h000000AA, 4'h1, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h3000, 32'h0000BB00, 4'h2, 1, 0, 0);
    // full with same-cycle pop, then merge while full
    addv(1, 32'h5000, 32'h00000001, 4'hF, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    addv(1, 32'h5004, 32'h00000002, 4'hF, 0, 32'h0,      1, 32'h5000, 32'h00000001, 4'hF, 1, 0, 0);
    addv(1, 32'h5008, 32'h00000003, 4'hF, 0, 32'h0,      1, 32'h5000, 32'h00000001, 4'hF, 1, 0, 0);
    addv(1, 32'h500C, 32'h00000004, 4'hF, 0, 32'h0,      1, 32'h5000, 32'h00000001, 4'hF, 1, 0, 0);
    addv(1, 32'h5010, 32'h00000005, 4'hF, 1, 32'h0,      1, 32'h5000, 32'h00000001, 4'hF, 0, 0, 0);
    addv(1, 32'h5010, 32'h00000005, 4'hF, 0, 32'h0,      1, 32'h5004, 32'h00000002, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,      1, 32'h5004, 32'h00000002, 4'hF, 0, 0, 0);
    addv(1, 32'h5012, 32'h00AB0000, 4'h4, 0, 32'h0,      1, 32'h5004, 32'h00000002, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h5004, 32'h00000002, 4'hF, 0, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h5008, 32'h00000003, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h500C, 32'h00000004, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h5010, 32'h00AB0005, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    // probe and zero-mask write
    addv(1, 32'h4000, 32'h12345678, 4'hF, 0, 32'h4003,   0, 32'h0,    32'h0,        4'h0, 1, 1, 1);
    addv(1, 32'h4008, 32'h9ABCDEF0, 4'hF, 0, 32'h4004,   1, 32'h4000, 32'h12345678, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h4003,   1, 32'h4000, 32'h12345678, 4'hF, 1, 1, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h4004,   1, 32'h4000, 32'h12345678, 4'hF, 1, 0, 0);
    addv(1, 32'h4004, 32'hFFFFFFFF, 4'h0, 0, 32'h4004,   1, 32'h4000, 32'h12345678, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h4004,   1, 32'h4000, 32'h12345678, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h4000,   1, 32'h4000, 32'h12345678, 4'hF, 1, 1, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h4004,   1, 32'h4008, 32'h9ABCDEF0, 4'hF, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h4004,   0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    // merge and pop together at count==2
    addv(1, 32'h6000, 32'h000000AA, 4'h1, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);
    addv(1, 32'h7000, 32'h000000BB, 4'h1, 0, 32'h0,      1, 32'h6000, 32'h000000AA, 4'h1, 1, 0, 0);
    addv(1, 32'h7000, 32'h0000CC00, 4'h2, 1, 32'h0,      1, 32'h6000, 32'h000000AA, 4'h1, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 1, 32'h0,      1, 32'h7000, 32'h0000CCBB, 4'h3, 1, 0, 0);
    addv(0, 32'h0,    32'h0,        4'h0, 0, 32'h0,      0, 32'h0,    32'h0,        4'h0, 1, 0, 1);

    // reset state
    #3;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_addr",  out_addr,       32'h0);
    chk("rst out_wdata", out_wdata,      32'h0);
    chk("rst out_wmask", 32'(out_wmask), 32'h0);
    chk("rst empty",     32'(empty),     32'd1);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst probe_hit", 32'(probe_hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].a, vecs[i].d, vecs[i].m, vecs[i].ordy, vecs[i].pa);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d out_addr", i),  out_addr,       vecs[i].e_addr);
        chk($sformatf("v%0d out_wdata", i), out_wdata,      vecs[i].e_data);
        chk($sformatf("v%0d out_wmask", i), 32'(out_wmask), 32'(vecs[i].e_mask));
      end
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("v%0d probe_hit", i), 32'(probe_hit), 32'(vecs[i].e_ph));
      chk($sformatf("v%0d empty", i),     32'(empty),     32'(vecs[i].e_emp));
    end

    // asynchronous reset mid-clock with three entries queued
    @(negedge clk); drive(1, 32'h9000, 32'h1, 4'hF, 0, 32'h0);
    @(negedge clk); drive(1, 32'h9004, 32'h2, 4'hF, 0, 32'h0);
    @(negedge clk); drive(1, 32'h9008, 32'h3, 4'hF, 0, 32'h0);
    @(negedge clk); drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h9004);
    #1;
    chk("pre-rst out_valid", 32'(out_valid), 32'd1);
    chk("pre-rst probe_hit", 32'(probe_hit), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst empty",     32'(empty),     32'd1);
    chk("async rst in_ready",  32'(in_ready),  32'd1);
    chk("async rst out_addr",  out_addr,       32'h0);
    chk("async rst out_wdata", out_wdata,      32'h0);
    chk("async rst probe_hit", 32'(probe_hit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h8000, 32'hFFFFABCD, 4'h3, 0, 32'h0);
    #1;
    chk("post-rst push same cycle out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    drive(0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    #1;
    chk("post-rst out_valid", 32'(out_valid), 32'd1);
    chk("post-rst out_addr",  out_addr,       32'h8000);
    chk("post-rst out_wdata", out_wdata,      32'h0000ABCD);
    chk("post-rst out_wmask", 32'(out_wmask), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
